// File: rtl/rr_arb_pkg.sv
// Shared helpers and types for the round-robin arbiter family.
// Bit-vector helpers work on a fixed wide vector so any arbiter up to
// ARB_MAX_N requesters can use them. Callers zero-extend on the way in and
// size-cast on the way out.
package rr_arb_pkg;

  localparam int ARB_MAX_N = 64;
  localparam int ARB_IDX_W = 6;

  typedef logic [ARB_MAX_N-1:0] arb_vec_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Lowest set bit, returned as one-hot. An all-zero input gives zero.
  function automatic arb_vec_t first_one(input arb_vec_t v);
    return v & (~v + arb_vec_t'(1));
  endfunction

  // Bits strictly above the one-hot position. A zero input gives zero.
  function automatic arb_vec_t mask_above(input arb_vec_t onehot);
    return ~(onehot | (onehot - arb_vec_t'(1)));
  endfunction

  // One-hot to binary index. The OR-reduction form keeps it a flat encoder.
  function automatic logic [ARB_IDX_W-1:0] onehot2idx(input arb_vec_t onehot);
    logic [ARB_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_MAX_N; i++)
      if (onehot[i]) idx = idx | ARB_IDX_W'(i);
    return idx;
  endfunction

endpackage

// File: rtl/fixed_priority_arbiter.sv
// LSB-first fixed priority arbiter. The output is one-hot, or zero when
// nothing requests.
module fixed_priority_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  // Lowest requesting bit wins.
  assign gnt = N'(first_one(arb_vec_t'(req)));

endmodule

// File: rtl/rr_pick.sv
// Masked round-robin pick. It prefers requesters above the last winner and
// wraps to the lowest requester when none are above. It also returns the
// mask to use after this winner.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  output logic [N-1:0] onehot,
  output logic [N-1:0] next_mask,
  output logic         any
);

  logic [N-1:0] masked_req;
  logic [N-1:0] gnt_masked;
  logic [N-1:0] gnt_wrap;

  assign masked_req = req & mask;

  fixed_priority_arbiter #(.N(N)) u_masked (
    .req (masked_req),
    .gnt (gnt_masked)
  );

  fixed_priority_arbiter #(.N(N)) u_wrap (
    .req (req),
    .gnt (gnt_wrap)
  );

  // Masked winner if any, else wrap to the lowest raw requester.
  assign onehot    = (|masked_req) ? gnt_masked : gnt_wrap;
  assign any       = |req;
  assign next_mask = N'(mask_above(arb_vec_t'(onehot)));

endmodule

// File: rtl/wrr_arbiter.sv
// N-way weighted round-robin arbiter with a registered one-hot grant and a
// valid/ready handshake. A winner holds the grant for up to weight+1
// accepted beats, then the pointer moves past it. N must be 2..64.
module wrr_arbiter
  import rr_arb_pkg::*;
#(
  parameter  int N  = 8,
  parameter  int WW = 4,
  localparam int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N*WW-1:0] weight,
  input  logic            wrr_en,
  output logic [N-1:0]    gnt,
  output logic [IW-1:0]   gnt_idx,
  output logic            gnt_valid,
  input  logic            gnt_ready
);

  arb_state_e            state;
  logic [N-1:0]          mask_q;
  logic [WW-1:0]         credit_q;

  logic [N-1:0][WW-1:0]  weight_arr;
  logic [N-1:0]          pick_oh;
  logic [N-1:0]          pick_mask;
  logic                  pick_any;
  logic [IW-1:0]         pick_idx;
  logic [WW-1:0]         pick_credit;
  logic                  keep;

  assign weight_arr = weight;

  rr_pick #(.N(N)) u_pick (
    .req       (req),
    .mask      (mask_q),
    .onehot    (pick_oh),
    .next_mask (pick_mask),
    .any       (pick_any)
  );

  assign pick_idx = IW'(onehot2idx(arb_vec_t'(pick_oh)));

  // Plain RR loads zero credit, so every accepted beat re-picks.
  assign pick_credit = wrr_en ? weight_arr[pick_idx] : '0;

  // Finish an in-flight credit even if wrr_en has since been cleared. A
  // credit is cut short only when its requester drops req.
  assign keep = (credit_q != '0) && req[gnt_idx];

  // Grant FSM: load a winner, hold until accept, then continue or re-pick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mask_q    <= '1;
      credit_q  <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            state     <= GRANT;
            gnt       <= pick_oh;
            gnt_idx   <= pick_idx;
            gnt_valid <= 1'b1;
            mask_q    <= pick_mask;
            credit_q  <= pick_credit;
          end
        end
        GRANT: begin
          if (gnt_ready) begin
            if (keep) begin
              credit_q <= credit_q - WW'(1);
            end else if (pick_any) begin
              gnt       <= pick_oh;
              gnt_idx   <= pick_idx;
              mask_q    <= pick_mask;
              credit_q  <= pick_credit;
            end else begin
              state     <= IDLE;
              gnt       <= '0;
              gnt_idx   <= '0;
              gnt_valid <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Bench for wrr_arbiter. It runs directed scenarios with known index
// sequences, then randomized traffic against a circular-search reference.
module tb_wrr_arbiter;

  localparam int N  = 8;
  localparam int WW = 4;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*WW-1:0] weight = '0;
  logic            wrr_en = 1'b1;
  logic            gnt_ready = 1'b0;
  logic [N-1:0]    gnt;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_valid;

  int n_chk = 0;
  int n_pass = 0;

  // Reference state: who holds the grant and how many extra beats remain.
  bit m_busy;
  int m_cur;
  int m_last;
  int m_extra;

  always #5 clk = ~clk;

  wrr_arbiter #(.N(N), .WW(WW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .weight    (weight),
    .wrr_en    (wrr_en),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .gnt_ready (gnt_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int wt(input int i);
    return int'(weight[i*WW +: WW]);
  endfunction

  // Next winner: first requester after the last winner, circularly.
  function automatic int m_pick();
    for (int i = m_last + 1; i < N; i++) if (req[i]) return i;
    for (int i = 0; i < N; i++) if (req[i]) return i;
    return -1;
  endfunction

  task automatic m_step();
    int p;
    if (!m_busy || gnt_ready) begin
      if (m_busy && m_extra > 0 && req[m_cur]) begin
        m_extra--;
      end else begin
        p = m_pick();
        if (p < 0) begin
          m_busy = 1'b0;
        end else begin
          m_busy  = 1'b1;
          m_cur   = p;
          m_last  = p;
          m_extra = wrr_en ? wt(p) : 0;
        end
      end
    end
  endtask

  task automatic m_reset();
    m_busy  = 1'b0;
    m_cur   = 0;
    m_last  = -1;
    m_extra = 0;
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    m_step();
    #1;
    chk({tag, "_valid"}, 32'(gnt_valid), 32'(m_busy));
    chk({tag, "_gnt"}, 32'(gnt), 32'(m_busy ? (1 << m_cur) : 0));
    chk({tag, "_idx"}, 32'(gnt_idx), 32'(m_busy ? m_cur : 0));
  endtask

  // Cycle plus a hard-coded expected index from the scenario description.
  task automatic cycle_exp(input string tag, input int e_idx, input bit e_vld);
    cycle(tag);
    chk({tag, "_seq_vld"}, 32'(gnt_valid), 32'(e_vld));
    chk({tag, "_seq_idx"}, 32'(gnt_idx), 32'(e_idx));
  endtask

  task automatic do_reset();
    req       = '0;
    gnt_ready = 1'b0;
    weight    = '0;
    wrr_en    = 1'b1;
    rst_n     = 1'b0;
    m_reset();
    #1;
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_valid", 32'(gnt_valid), 32'(0));
    chk("rst_idx", 32'(gnt_idx), 32'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] r;
    int seq2 [8] = '{0, 1, 2, 2, 2, 2, 3, 4};

    // 1: all requesting, zero weights, always ready -> 0..7,0
    do_reset();
    req = 8'hFF; gnt_ready = 1'b1;
    for (int i = 0; i < 9; i++) cycle_exp("t1", i % 8, 1'b1);

    // 2: weight[2]=3 gives idx 2 for four beats
    do_reset();
    req = 8'hFF; gnt_ready = 1'b1;
    weight[2*WW +: WW] = 4'd3;
    for (int i = 0; i < 8; i++) cycle_exp("t2w", seq2[i], 1'b1);
    // same weights in plain RR: idx 2 once
    do_reset();
    req = 8'hFF; gnt_ready = 1'b1; wrr_en = 1'b0;
    weight[2*WW +: WW] = 4'd3;
    for (int i = 0; i < 5; i++) cycle_exp("t2rr", i, 1'b1);

    // 3: sole requester held under back-pressure, then accepted
    do_reset();
    req = 8'h10;
    cycle_exp("t3_hold", 4, 1'b1);
    for (int i = 0; i < 5; i++) cycle_exp("t3_hold", 4, 1'b1);
    gnt_ready = 1'b1;
    cycle_exp("t3_rewin", 4, 1'b1);
    // 6: drop req at accept -> idle, then a new request one cycle later
    req = 8'h00;
    cycle_exp("t6_idle", 0, 1'b0);
    cycle_exp("t6_idle2", 0, 1'b0);
    req = 8'h04;
    cycle_exp("t6_new", 2, 1'b1);
    chk("t6_gnt", 32'(gnt), 32'h04);

    // 4: two requesters alternate, then the survivor wraps with no bubble
    do_reset();
    req = 8'h81; gnt_ready = 1'b1;
    cycle_exp("t4", 0, 1'b1);
    cycle_exp("t4", 7, 1'b1);
    cycle_exp("t4", 0, 1'b1);
    cycle_exp("t4", 7, 1'b1);
    req = 8'h80;
    cycle_exp("t4_wrap", 7, 1'b1);
    cycle_exp("t4_wrap", 7, 1'b1);

    // 5: async reset while a weighted grant is held
    do_reset();
    req = 8'hFF; weight[0 +: WW] = 4'd2;
    cycle_exp("t5_pre", 0, 1'b1);
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    chk("t5_async_gnt", 32'(gnt), 32'(0));
    chk("t5_async_valid", 32'(gnt_valid), 32'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    gnt_ready = 1'b1;
    cycle_exp("t5_post", 0, 1'b1);

    // Random traffic against the reference
    do_reset();
    for (int i = 0; i < 800; i++) begin
      gnt_ready = ($urandom_range(0, 3) != 0);
      r = N'($urandom);
      if ($urandom_range(0, 1) == 1) r = r & N'($urandom);
      if ($urandom_range(0, 7) == 0) r = '0;
      if (m_busy && !gnt_ready) r[m_cur] = 1'b1;
      req    = r;
      weight = ($urandom_range(0, 1) == 1) ? (N*WW)'($urandom) : (N*WW)'($urandom & 32'h1111_1111);
      if ($urandom_range(0, 15) == 0) wrr_en = ~wrr_en;
      cycle("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
